// File: rtl/dmem_responder.sv
// dmem_responder: target end of the memory-stage load/store interface.
// One request at a time, fixed wait of LATENCY cycles before the storage
// access, then a response held until the requester takes it.
module dmem_responder #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              accept, access;

    logic              write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              resp_valid_reg;
    logic              resp_err_reg;
    logic              load_ok_reg;
    logic [DATA_W-1:0] mem_q_reg;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              in_range;

    assign idx = addr_reg[IDX_W-1:0];

    // When every address the port can express is implemented, no compare is needed.
    generate
        if ((1 << ADDR_W) <= DEPTH) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_cmp_range
            assign in_range = (32'(addr_reg) < 32'(DEPTH));
        end
    endgenerate

    // A request is only taken in IDLE and never while reset is asserted.
    assign req_ready = (state_reg == S_IDLE) && !rst;

    // Next-state logic: the counter reaching zero in WAIT marks the access edge.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        access     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(LATENCY);
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    access     = 1'b1;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Capture the request so the requester may change its inputs after acceptance.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            write_reg <= req_write;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
        end
    end

    // Storage array with registered read; out-of-range and reset-coincident stores are dropped.
    always_ff @(posedge clk) begin
        if (access && !rst) begin
            if (write_reg && in_range) begin
                mem[idx] <= wdata_reg;
            end
            mem_q_reg <= mem[idx];
        end
    end

    // Response flags: set at the access edge, held until the requester consumes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            load_ok_reg    <= 1'b0;
        end else if (access) begin
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= !in_range;
            load_ok_reg    <= !write_reg && in_range;
        end else if ((state_reg == S_RESP) && resp_ready) begin
            resp_valid_reg <= 1'b0;
        end
    end

    // Load data is forced to zero for stores and errors, so the array output needs no reset.
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = load_ok_reg ? mem_q_reg : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table-driven load/store vectors on a LATENCY=2
// instance with a response scoreboard, hand sequences for reset corners,
// and a short LATENCY=0 instance sequence.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [12:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_resp_ready = 1'b0;
    logic [12:0] z_req_addr = '0;
    logic [31:0] z_req_wdata = '0;
    logic        z_req_ready, z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        w;
        logic [12:0] a;
        logic [31:0] d;
        logic [31:0] er;
        logic        ee;
        int          hold;
        bit          gap;
    } vec_t;
    vec_t tbl[13];

    dmem_responder #(.ADDR_W(13), .DATA_W(32), .DEPTH(4096), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.ADDR_W(13), .DATA_W(32), .DEPTH(4096), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete transaction on the LATENCY=2 instance: accept, wait, check, consume.
    task automatic issue(input logic w, input logic [12:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic ee, input int hold,
                         input bit gap, input string nm);
        int   n;
        int   lat;
        exp_t e;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " ready_before"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = (hold == 0);
        sbq.push_back('{rd: er, err: ee});
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 13'($urandom);
        req_wdata = $urandom;
        chk({nm, " ready_after_accept"}, 32'(req_ready), 32'd0);
        if (gap) chk({nm, " spacing"}, 32'(cyc - last_acc), 32'(LAT + 3));
        last_acc = cyc;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(LAT + 2));
        e = sbq.pop_front();
        chk({nm, " rdata"}, resp_rdata, e.rd);
        chk({nm, " err"}, 32'(resp_err), 32'(e.err));
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1;
            req_addr  = 13'($urandom);
            @(negedge clk);
            chk({nm, " hold_valid"}, 32'(resp_valid), 32'd1);
            chk({nm, " hold_rdata"}, resp_rdata, e.rd);
            chk({nm, " hold_err"}, 32'(resp_err), 32'(e.err));
            chk({nm, " hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk({nm, " consumed_valid"}, 32'(resp_valid), 32'd0);
        chk({nm, " ready_return"}, 32'(req_ready), 32'd1);
        resp_ready = 1'b0;
    endtask

    initial begin
        int acc0;
        tbl[0]  = '{1'b1, 13'h010, 32'hDEADBEEF, 32'h0,        1'b0, 0, 1'b0};
        tbl[1]  = '{1'b0, 13'h010, 32'h0,        32'hDEADBEEF, 1'b0, 0, 1'b1};
        tbl[2]  = '{1'b0, 13'h010, 32'h0,        32'hDEADBEEF, 1'b0, 5, 1'b1};
        tbl[3]  = '{1'b1, 13'h000, 32'h00000055, 32'h0,        1'b0, 0, 1'b0};
        tbl[4]  = '{1'b1, 13'h1000, 32'h12345678, 32'h0,       1'b1, 0, 1'b1};
        tbl[5]  = '{1'b0, 13'h1000, 32'h0,       32'h0,        1'b1, 0, 1'b1};
        tbl[6]  = '{1'b0, 13'h000, 32'h0,        32'h00000055, 1'b0, 0, 1'b1};
        tbl[7]  = '{1'b1, 13'h0FFF, 32'h11112222, 32'h0,       1'b0, 0, 1'b1};
        tbl[8]  = '{1'b0, 13'h0FFF, 32'h0,       32'h11112222, 1'b0, 0, 1'b1};
        tbl[9]  = '{1'b0, 13'h1FFF, 32'h0,       32'h0,        1'b1, 0, 1'b1};
        tbl[10] = '{1'b1, 13'h020, 32'h0000AAAA, 32'h0,        1'b0, 0, 1'b1};
        tbl[11] = '{1'b1, 13'h030, 32'h00000BB0, 32'h0,        1'b0, 0, 1'b1};
        tbl[12] = '{1'b0, 13'h030, 32'h0,        32'h00000BB0, 1'b0, 2, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            issue(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].er, tbl[i].ee,
                  tbl[i].hold, tbl[i].gap, $sformatf("v%0d", i));
            $display("vec %0d write=%0b addr=%h wdata=%h -> rdata=%h err=%0b",
                     i, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].er, tbl[i].ee);
        end

        // Reset one edge after accepting a store: the store must vanish.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 13'h020; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst ready_in_rst", 32'(req_ready), 32'd0);
        chk("midrst valid_in_rst", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst ready_after", 32'(req_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("midrst no_resp", 32'(resp_valid), 32'd0);
        end
        issue(1'b0, 13'h020, 32'h0, 32'h0000AAAA, 1'b0, 0, 1'b0, "midrst load");
        $display("seq midrst store 020 discarded -> load %h", 32'h0000AAAA);

        // Reset coinciding with the access edge: store must also vanish.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 13'h030; req_wdata = 32'hDEAD0030;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("accrst valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        #1;
        issue(1'b0, 13'h030, 32'h0, 32'h00000BB0, 1'b0, 0, 1'b0, "accrst load");
        $display("seq accrst store 030 discarded -> load %h", 32'h00000BB0);

        chk("scoreboard empty", 32'(sbq.size()), 32'd0);

        // LATENCY=0 instance: store then load to 0x7FF with 3-cycle spacing.
        chk("z ready_idle", 32'(z_req_ready), 32'd1);
        z_resp_ready = 1'b1;
        z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 13'h7FF; z_req_wdata = 32'hA5A55A5A;
        @(negedge clk);
        acc0 = cyc;
        z_req_valid = 1'b0;
        chk("z st cycT_valid", 32'(z_resp_valid), 32'd0);
        @(negedge clk);
        chk("z st valid", 32'(z_resp_valid), 32'd1);
        chk("z st rdata", z_resp_rdata, 32'd0);
        chk("z st err", 32'(z_resp_err), 32'd0);
        chk("z st ready_busy", 32'(z_req_ready), 32'd0);
        @(negedge clk);
        chk("z st consumed", 32'(z_resp_valid), 32'd0);
        chk("z st ready_return", 32'(z_req_ready), 32'd1);
        z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 13'h7FF; z_req_wdata = 32'h0;
        @(negedge clk);
        z_req_valid = 1'b0;
        chk("z spacing", 32'(cyc - acc0), 32'd3);
        @(negedge clk);
        chk("z ld valid", 32'(z_resp_valid), 32'd1);
        chk("z ld rdata", z_resp_rdata, 32'hA5A55A5A);
        chk("z ld err", 32'(z_resp_err), 32'd0);
        @(negedge clk);
        chk("z ld consumed", 32'(z_resp_valid), 32'd0);
        z_resp_ready = 1'b0;
        $display("seq lat0 store/load 7FF -> %h", 32'hA5A55A5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
